// File: rtl/ifm_mem_ctrl.sv
// ifm_mem_ctrl: loads one IFM into memory in raster order, then streams it back
// as (even, odd) pixel pairs using both memory ports in parallel.
`default_nettype none

module ifm_mem_ctrl #(
  parameter int DATA_WIDTH       = 32,
  parameter int IFM_SIZE         = 16,
  parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE*IFM_SIZE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        Start_Load,
  input  logic                        In_Valid,
  output logic                        In_Ready,
  input  logic [DATA_WIDTH-1:0]       Data_In,
  output logic                        Loaded,
  input  logic                        Start_Read,
  output logic                        Out_Valid,
  output logic [DATA_WIDTH-1:0]       Data_Out_Even,
  output logic [DATA_WIDTH-1:0]       Data_Out_Odd,
  output logic                        Read_Done,
  output logic [ADDRESS_SIZE_IFM-1:0] Address_A,
  output logic [ADDRESS_SIZE_IFM-1:0] Address_B,
  output logic                        Enable_Write_A_Mem,
  output logic                        Enable_Read_A_Mem,
  output logic                        Enable_Write_B_Mem,
  output logic                        Enable_Read_B_Mem,
  output logic [DATA_WIDTH-1:0]       Data_Input_A_Mem1,
  output logic [DATA_WIDTH-1:0]       Data_Input_B_Mem1,
  input  logic [DATA_WIDTH-1:0]       Data_Output_A_Mem1,
  input  logic [DATA_WIDTH-1:0]       Data_Output_B_Mem1
);

  localparam int N  = IFM_SIZE * IFM_SIZE;
  localparam int CW = ADDRESS_SIZE_IFM + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FULL  = 3'd2,
    S_READ  = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_wr_cnt;
  logic [CW-1:0]         r_rd_cnt;
  logic                  r_loaded;
  logic                  r_out_valid;
  logic                  r_read_done;
  logic [DATA_WIDTH-1:0] r_even_hold;
  logic [DATA_WIDTH-1:0] r_odd_hold;

  logic                        w_wr;
  logic                        w_rd;
  logic                        w_rd_last;
  logic [ADDRESS_SIZE_IFM-1:0] w_rd_addr_even;
  logic [ADDRESS_SIZE_IFM-1:0] w_rd_addr_odd;

  assign w_wr           = (r_state == S_LOAD) && In_Valid;
  assign w_rd           = (r_state == S_READ);
  assign w_rd_last      = (r_rd_cnt == CW'(N/2 - 1));
  assign w_rd_addr_even = {r_rd_cnt[ADDRESS_SIZE_IFM-2:0], 1'b0};
  assign w_rd_addr_odd  = {r_rd_cnt[ADDRESS_SIZE_IFM-2:0], 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_loaded    <= 1'b0;
      r_out_valid <= 1'b0;
      r_read_done <= 1'b0;
      r_even_hold <= '0;
      r_odd_hold  <= '0;
    end else begin
      r_out_valid <= w_rd;
      r_read_done <= w_rd && w_rd_last;
      if (r_out_valid) begin
        r_even_hold <= Data_Output_A_Mem1;
        r_odd_hold  <= Data_Output_B_Mem1;
      end
      case (r_state)
        S_IDLE: begin
          if (Start_Load) begin
            r_state  <= S_LOAD;
            r_wr_cnt <= '0;
            r_loaded <= 1'b0;
          end
        end
        S_LOAD: begin
          if (In_Valid) begin
            r_wr_cnt <= r_wr_cnt + 1'b1;
            if (r_wr_cnt == CW'(N - 1)) begin
              r_state  <= S_FULL;
              r_loaded <= 1'b1;
            end
          end
        end
        S_FULL: begin
          // A simultaneous load request loses to the read.
          if (Start_Read) begin
            r_state  <= S_READ;
            r_rd_cnt <= '0;
          end else if (Start_Load) begin
            r_state  <= S_LOAD;
            r_wr_cnt <= '0;
            r_loaded <= 1'b0;
          end
        end
        S_READ: begin
          r_rd_cnt <= r_rd_cnt + 1'b1;
          if (w_rd_last) r_state <= S_FLUSH;
        end
        S_FLUSH: r_state <= S_FULL;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign In_Ready           = (r_state == S_LOAD);
  assign Loaded             = r_loaded;
  assign Out_Valid          = r_out_valid;
  assign Read_Done          = r_read_done;
  // Memory data arrives in the Out_Valid cycle; the hold registers keep it afterwards.
  assign Data_Out_Even      = r_out_valid ? Data_Output_A_Mem1 : r_even_hold;
  assign Data_Out_Odd       = r_out_valid ? Data_Output_B_Mem1 : r_odd_hold;

  assign Enable_Write_A_Mem = w_wr;
  assign Enable_Read_A_Mem  = w_rd;
  assign Enable_Write_B_Mem = 1'b0;
  assign Enable_Read_B_Mem  = w_rd;
  assign Data_Input_A_Mem1  = w_wr ? Data_In : '0;
  assign Data_Input_B_Mem1  = '0;
  assign Address_A          = w_wr ? r_wr_cnt[ADDRESS_SIZE_IFM-1:0] :
                              (w_rd ? w_rd_addr_even : '0);
  assign Address_B          = w_rd ? w_rd_addr_odd : '0;

endmodule

`default_nettype wire

// File: doc/ifm_mem_ctrl.md
IFM_MEM_CTRL -- requirements
Module: ifm_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width of IFM data.
REQ-002 SHALL have parameter IFM_SIZE, default 16, feature-map side; IFM_SIZE SHALL be even.
REQ-003 SHALL have parameter ADDRESS_SIZE_IFM, default $clog2(IFM_SIZE*IFM_SIZE), memory address width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; ports below.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 Start_Load  in  1  one-cycle request to begin loading a new IFM.
REQ-008 In_Valid  in  1  Data_In holds a valid pixel.
REQ-009 In_Ready  out  1  controller accepts Data_In this cycle.
REQ-010 Data_In  in  DATA_WIDTH  input pixel, raster order.
REQ-011 Loaded  out  1  complete IFM resident in memory.
REQ-012 Start_Read  in  1  one-cycle request to stream the stored IFM out.
REQ-013 Out_Valid  out  1  Data_Out_Even/Data_Out_Odd valid this cycle.
REQ-014 Data_Out_Even / Data_Out_Odd  out  DATA_WIDTH each  pixels at addresses 2k and 2k+1.
REQ-015 Read_Done  out  1  one-cycle pulse coincident with the last output pair.
REQ-016 Address_A, Address_B  out  ADDRESS_SIZE_IFM each  memory port addresses.
REQ-017 Enable_Write_A_Mem, Enable_Read_A_Mem, Enable_Write_B_Mem, Enable_Read_B_Mem  out  1 each  memory port strobes.
REQ-018 Data_Input_A_Mem1, Data_Input_B_Mem1  out  DATA_WIDTH each  memory write data.
REQ-019 Data_Output_A_Mem1, Data_Output_B_Mem1  in  DATA_WIDTH each  memory read data, valid 1 cycle after read strobe.

Function
REQ-020 SHALL implement states IDLE, LOAD, FULL, READ, FLUSH; N = IFM_SIZE*IFM_SIZE.
REQ-021 IDLE: Start_Load -> LOAD, write counter cleared, Loaded=0; Start_Read ignored.
REQ-022 LOAD: In_Ready=1; on In_Valid&&In_Ready, drive Enable_Write_A_Mem=1, Address_A=wr_cnt, Data_Input_A_Mem1=Data_In, wr_cnt+1, all combinationally in the same cycle.
REQ-023 LOAD: In_Valid low -> no write, wr_cnt holds; gaps of any length allowed.
REQ-024 LOAD: accepted write at wr_cnt=N-1 -> FULL next cycle, Loaded=1, In_Ready=0 from that cycle.
REQ-025 Port B SHALL never be written: Enable_Write_B_Mem=0, Data_Input_B_Mem1=0 always.
REQ-026 FULL: Start_Read -> READ with rd_cnt=0; Start_Load -> LOAD (Loaded=0); both high -> Start_Read wins.
REQ-027 READ: each cycle assert both read enables, Address_A=2*rd_cnt, Address_B=2*rd_cnt+1, rd_cnt+1; N/2 cycles, no stalls.
REQ-028 READ issuing rd_cnt=N/2-1 -> FLUSH; FLUSH lasts 1 cycle, then FULL (Loaded stays 1, IFM re-readable).
REQ-029 Out_Valid SHALL be the read-issue strobe delayed 1 cycle; Data_Out_Even/Odd registered copies of Data_Output_A/B_Mem1 captured when Out_Valid asserts, held otherwise.
REQ-030 Read_Done SHALL pulse with the Out_Valid of the pair from rd_cnt=N/2-1 (during FLUSH).
REQ-031 Start_Load/Start_Read in READ or FLUSH SHALL be ignored; Start_Load in LOAD ignored.
REQ-032 Outside LOAD writes and READ reads, all memory enables 0 and addresses 0.
REQ-033 Counters SHALL be ADDRESS_SIZE_IFM+1 bits wide; no wrap within an operation.

Reset
REQ-034 reset low SHALL immediately force IDLE, counters 0, In_Ready=0, Loaded=0, Out_Valid=0, Read_Done=0, Data_Out_* =0, all memory strobes/addresses/data 0.
REQ-035 Reset mid-LOAD or mid-READ SHALL abort silently; memory contents not cleared; Loaded=0 after release.

Verification (IFM_SIZE=4, N=16)
REQ-036 Start_Load, 16 back-to-back words 0..15 -> 16 writes at addresses 0..15, Loaded=1 the cycle after the 16th accept.
REQ-037 Load with In_Valid toggling every other cycle -> exactly 16 writes, addresses strictly increasing, no duplicates.
REQ-038 After load, Start_Read -> 8 consecutive Out_Valid pairs (0,1),(2,3)..(14,15), first 2 cycles after Start_Read, Read_Done with (14,15).
REQ-039 Start_Read and Start_Load together in FULL -> read proceeds, no write strobes; second Start_Read after FLUSH repeats identical stream.
REQ-040 reset asserted after 7 accepted words -> all outputs 0 immediately, IDLE; Start_Read then ignored (no Out_Valid).
REQ-041 Start_Load during READ -> ignored, stream of 8 pairs completes unchanged.
